// File: rtl/reg_file_mp_pkg.sv
// ---------------------------------------------------------------------------
// reg_file_mp_pkg
// Shared defaults and address-window helpers for the multi-port register
// file and its read ports.
//
// Contents:
//   DEF_DATA_W, DEF_ADDR_W, DEF_NUM_REGS, DEF_REG_BASE : parameter defaults
//   addr_in_window() : 1 when an architectural address maps onto a register
//   addr_to_index()  : architectural address -> physical register index
// ---------------------------------------------------------------------------
package reg_file_mp_pkg;

   localparam int unsigned DEF_DATA_W   = 32;
   localparam int unsigned DEF_ADDR_W   = 5;
   localparam int unsigned DEF_NUM_REGS = 16;
   localparam int unsigned DEF_REG_BASE = 8;

   // The window is [base, base+num-1].
   // Addresses below the base are outside it and never wrap around.
   function automatic logic addr_in_window(input int unsigned addr,
                                           input int unsigned base,
                                           input int unsigned num);
      return (addr >= base) && (addr < base + num);
   endfunction

   // The result is only meaningful when addr_in_window() is true.
   function automatic int unsigned addr_to_index(input int unsigned addr,
                                                 input int unsigned base);
      return addr - base;
   endfunction

endpackage

// File: rtl/reg_file_rd_port.sv
// ---------------------------------------------------------------------------
// reg_file_rd_port
// One registered read port of reg_file_mp. It decodes its own address and
// applies the same-cycle write bypass. It registers data and busy status,
// and it holds both while the port enable is low.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   en          : port update enable
//   addr        : architectural read address
//   wr_hit      : a write that really updates a register this cycle
//   wr_addr     : address of that write
//   wr_data     : data of that write
//   regs        : current register contents
//   busy_next   : next-state busy vector (after reserve/write this cycle)
//   data, busy  : registered read data and busy status
//   err         : enabled access to an out-of-window address (combinational)
// ---------------------------------------------------------------------------
module reg_file_rd_port
   import reg_file_mp_pkg::*;
#(
   parameter int unsigned DATA_W        = DEF_DATA_W,
   parameter int unsigned ADDR_W        = DEF_ADDR_W,
   parameter int unsigned NUM_REGS      = DEF_NUM_REGS,
   parameter int unsigned REG_BASE      = DEF_REG_BASE,
   parameter int unsigned HARDWIRE_ZERO = 0,
   parameter int unsigned IDX_W         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             en,
   input  logic [ADDR_W-1:0]                addr,
   input  logic                             wr_hit,
   input  logic [ADDR_W-1:0]                wr_addr,
   input  logic [DATA_W-1:0]                wr_data,
   input  logic [NUM_REGS-1:0][DATA_W-1:0]  regs,
   input  logic [NUM_REGS-1:0]              busy_next,
   output logic [DATA_W-1:0]                data,
   output logic                             busy,
   output logic                             err
);

   logic              valid;
   logic [IDX_W-1:0]  idx;
   logic [DATA_W-1:0] next_data;
   logic              next_busy;

   assign valid = addr_in_window(32'(addr), REG_BASE, NUM_REGS);
   assign idx   = IDX_W'(addr_to_index(32'(addr), REG_BASE));
   assign err   = en && !valid;

   // An out-of-window read returns zero and not busy.
   // A read of the hardwired zero register returns zero.
   // A read that matches a real write this cycle returns the write data.
   // Otherwise the read returns the stored register value.
   always_comb begin
      next_data = '0;
      next_busy = 1'b0;
      if (valid) begin
         if ((HARDWIRE_ZERO != 0) && (idx == '0))
            next_data = '0;
         else if (wr_hit && (wr_addr == addr))
            next_data = wr_data;
         else
            next_data = regs[idx];
         next_busy = busy_next[idx];
      end
   end

   // The output registers update only when the port is enabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data <= '0;
         busy <= 1'b0;
      end else if (en) begin
         data <= next_data;
         busy <= next_busy;
      end
   end

endmodule

// File: rtl/reg_file_mp.sv
// ---------------------------------------------------------------------------
// reg_file_mp
// Register file with one write port, two registered read ports with
// write bypass, and address-window decoding. It also keeps a per-register
// busy scoreboard for producer reservation and a sticky address-error flag.
//
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   wrEn, wrAddr, wrData       : write port
//   rdEnA, rdAddrA             : read port A enable and address
//   rdDataA, busyA             : registered read data and busy status A
//   rdEnB, rdAddrB             : read port B enable and address
//   rdDataB, busyB             : registered read data and busy status B
//   rsvEn, rsvAddr             : reserve (mark busy) request
//   errClr                     : clear the sticky error
//   addrErr                    : sticky out-of-window address error
// ---------------------------------------------------------------------------
module reg_file_mp
   import reg_file_mp_pkg::*;
#(
   parameter int unsigned DATA_W        = DEF_DATA_W,
   parameter int unsigned NUM_REGS      = DEF_NUM_REGS,
   parameter int unsigned ADDR_W        = DEF_ADDR_W,
   parameter int unsigned REG_BASE      = DEF_REG_BASE,
   parameter int unsigned HARDWIRE_ZERO = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wrEn,
   input  logic [ADDR_W-1:0] wrAddr,
   input  logic [DATA_W-1:0] wrData,
   input  logic              rdEnA,
   input  logic [ADDR_W-1:0] rdAddrA,
   output logic [DATA_W-1:0] rdDataA,
   output logic              busyA,
   input  logic              rdEnB,
   input  logic [ADDR_W-1:0] rdAddrB,
   output logic [DATA_W-1:0] rdDataB,
   output logic              busyB,
   input  logic              rsvEn,
   input  logic [ADDR_W-1:0] rsvAddr,
   input  logic              errClr,
   output logic              addrErr
);

   localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   logic [NUM_REGS-1:0][DATA_W-1:0] regs;
   logic [NUM_REGS-1:0]             busy;
   logic [NUM_REGS-1:0]             busy_next;

   logic             wr_valid, rsv_valid;
   logic [IDX_W-1:0] wr_idx, rsv_idx;
   logic             wr_hit, rsv_hit;
   logic             err_a, err_b;
   logic             err_set;

   assign wr_valid  = addr_in_window(32'(wrAddr), REG_BASE, NUM_REGS);
   assign rsv_valid = addr_in_window(32'(rsvAddr), REG_BASE, NUM_REGS);
   assign wr_idx    = IDX_W'(addr_to_index(32'(wrAddr), REG_BASE));
   assign rsv_idx   = IDX_W'(addr_to_index(32'(rsvAddr), REG_BASE));

   // The hardwired zero register ignores writes and reservations without
   // raising an error. These hit signals therefore exclude index 0 in that mode.
   assign wr_hit  = wrEn && wr_valid &&
                    !((HARDWIRE_ZERO != 0) && (wr_idx == '0));
   assign rsv_hit = rsvEn && rsv_valid &&
                    !((HARDWIRE_ZERO != 0) && (rsv_idx == '0));

   // The write retires its producer, and the reserve marks a new producer.
   // When both hit the same register, the reserve is applied last so it wins.
   always_comb begin
      busy_next = busy;
      if (wr_hit)
         busy_next[wr_idx] = 1'b0;
      if (rsv_hit)
         busy_next[rsv_idx] = 1'b1;
   end

   // Register storage and busy scoreboard.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs <= '0;
         busy <= '0;
      end else begin
         if (wr_hit)
            regs[wr_idx] <= wrData;
         busy <= busy_next;
      end
   end

   // The error flag is sticky. A new bad access wins over a clear in the same cycle.
   assign err_set = (wrEn && !wr_valid) || (rsvEn && !rsv_valid) || err_a || err_b;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         addrErr <= 1'b0;
      else if (err_set)
         addrErr <= 1'b1;
      else if (errClr)
         addrErr <= 1'b0;
   end

   reg_file_rd_port #(
      .DATA_W        (DATA_W),
      .ADDR_W        (ADDR_W),
      .NUM_REGS      (NUM_REGS),
      .REG_BASE      (REG_BASE),
      .HARDWIRE_ZERO (HARDWIRE_ZERO),
      .IDX_W         (IDX_W)
   ) u_port_a (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (rdEnA),
      .addr      (rdAddrA),
      .wr_hit    (wr_hit),
      .wr_addr   (wrAddr),
      .wr_data   (wrData),
      .regs      (regs),
      .busy_next (busy_next),
      .data      (rdDataA),
      .busy      (busyA),
      .err       (err_a)
   );

   reg_file_rd_port #(
      .DATA_W        (DATA_W),
      .ADDR_W        (ADDR_W),
      .NUM_REGS      (NUM_REGS),
      .REG_BASE      (REG_BASE),
      .HARDWIRE_ZERO (HARDWIRE_ZERO),
      .IDX_W         (IDX_W)
   ) u_port_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (rdEnB),
      .addr      (rdAddrB),
      .wr_hit    (wr_hit),
      .wr_addr   (wrAddr),
      .wr_data   (wrData),
      .regs      (regs),
      .busy_next (busy_next),
      .data      (rdDataB),
      .busy      (busyB),
      .err       (err_b)
   );

endmodule

// File: tb/tb_reg_file_mp.sv
// ---------------------------------------------------------------------------
// tb_reg_file_mp
// Scoreboard bench for reg_file_mp. Two DUTs share the same stimulus:
// dut0 is built with HARDWIRE_ZERO=0 and dut1 with HARDWIRE_ZERO=1.
// The bench keeps a behavioural model with the register contents, the busy
// flags and the error flag. On each stimulus cycle the expected outputs are
// pushed into a queue. A monitor process pops that queue one cycle later and
// compares against the DUT.
// ---------------------------------------------------------------------------
module tb_reg_file_mp;

   localparam int BASE = 8;
   localparam int NREG = 16;

   typedef struct packed {
      logic [31:0] da;
      logic        ba;
      logic [31:0] db;
      logic        bb;
      logic        er;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        wrEn, rdEnA, rdEnB, rsvEn, errClr;
   logic [4:0]  wrAddr, rdAddrA, rdAddrB, rsvAddr;
   logic [31:0] wrData;

   logic [31:0] rdDataA0, rdDataB0, rdDataA1, rdDataB1;
   logic        busyA0, busyB0, busyA1, busyB1, addrErr0, addrErr1;

   int checks   = 0;
   int failures = 0;

   exp_t sb0[$];
   exp_t sb1[$];

   // Behavioural model state, indexed [dut][physical register].
   logic [31:0] m_mem  [2][NREG];
   bit          m_busy [2][NREG];
   bit          m_err  [2];
   exp_t        m_out  [2];

   reg_file_mp #(.HARDWIRE_ZERO(0)) dut0 (
      .clk(clk), .rst_n(rst_n),
      .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData),
      .rdEnA(rdEnA), .rdAddrA(rdAddrA), .rdDataA(rdDataA0), .busyA(busyA0),
      .rdEnB(rdEnB), .rdAddrB(rdAddrB), .rdDataB(rdDataB0), .busyB(busyB0),
      .rsvEn(rsvEn), .rsvAddr(rsvAddr), .errClr(errClr), .addrErr(addrErr0)
   );

   reg_file_mp #(.HARDWIRE_ZERO(1)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData),
      .rdEnA(rdEnA), .rdAddrA(rdAddrA), .rdDataA(rdDataA1), .busyA(busyA1),
      .rdEnB(rdEnB), .rdAddrB(rdAddrB), .rdDataB(rdDataB1), .busyB(busyB1),
      .rsvEn(rsvEn), .rsvAddr(rsvAddr), .errClr(errClr), .addrErr(addrErr1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit inWin(input logic [4:0] a);
      return (int'(a) >= BASE) && (int'(a) < BASE + NREG);
   endfunction

   task automatic modelReset();
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < NREG; i++) begin
            m_mem[d][i]  = '0;
            m_busy[d][i] = 1'b0;
         end
         m_err[d] = 1'b0;
         m_out[d] = '0;
      end
   endtask

   // Advance the model by one clock using the inputs currently driven.
   // Reads see the register and busy state as it stands after this cycle's
   // write and reserve have taken effect.
   task automatic modelStep(input int d);
      bit hz;
      bit bad;
      int wi, ri, ai, bi;
      hz = (d == 1);
      wi = int'(wrAddr) - BASE;
      ri = int'(rsvAddr) - BASE;
      ai = int'(rdAddrA) - BASE;
      bi = int'(rdAddrB) - BASE;
      if (wrEn && inWin(wrAddr) && !(hz && wi == 0)) begin
         m_mem[d][wi]  = wrData;
         m_busy[d][wi] = 1'b0;
      end
      if (rsvEn && inWin(rsvAddr) && !(hz && ri == 0))
         m_busy[d][ri] = 1'b1;
      if (rdEnA) begin
         m_out[d].da = inWin(rdAddrA) ? m_mem[d][ai] : 32'h0;
         m_out[d].ba = inWin(rdAddrA) ? m_busy[d][ai] : 1'b0;
      end
      if (rdEnB) begin
         m_out[d].db = inWin(rdAddrB) ? m_mem[d][bi] : 32'h0;
         m_out[d].bb = inWin(rdAddrB) ? m_busy[d][bi] : 1'b0;
      end
      bad = (wrEn && !inWin(wrAddr)) || (rsvEn && !inWin(rsvAddr)) ||
            (rdEnA && !inWin(rdAddrA)) || (rdEnB && !inWin(rdAddrB));
      if (bad)
         m_err[d] = 1'b1;
      else if (errClr)
         m_err[d] = 1'b0;
      m_out[d].er = m_err[d];
   endtask

   // Drive one cycle of inputs, advance the model and queue the expected
   // outputs for the following clock edge.
   task automatic applyStimulus(input logic we, input logic [4:0] wa,
                                input logic [31:0] wd,
                                input logic rea, input logic [4:0] ra,
                                input logic reb, input logic [4:0] rb,
                                input logic rse, input logic [4:0] rsa,
                                input logic clr);
      @(negedge clk);
      wrEn = we;  wrAddr = wa;  wrData = wd;
      rdEnA = rea; rdAddrA = ra;
      rdEnB = reb; rdAddrB = rb;
      rsvEn = rse; rsvAddr = rsa;
      errClr = clr;
      modelStep(0);
      modelStep(1);
      sb0.push_back(m_out[0]);
      sb1.push_back(m_out[1]);
   endtask

   task automatic idle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   function automatic logic [4:0] randAddr();
      if ($urandom_range(0, 9) < 8)
         return 5'($urandom_range(BASE, BASE + NREG - 1));
      return 5'($urandom_range(0, 31));
   endfunction

   task automatic checkAllZero(input string tag);
      checkOutput({tag, " dut0 rdDataA"}, rdDataA0, 32'h0);
      checkOutput({tag, " dut0 rdDataB"}, rdDataB0, 32'h0);
      checkOutput({tag, " dut0 busyA"}, 32'(busyA0), 32'h0);
      checkOutput({tag, " dut0 busyB"}, 32'(busyB0), 32'h0);
      checkOutput({tag, " dut0 addrErr"}, 32'(addrErr0), 32'h0);
      checkOutput({tag, " dut1 rdDataA"}, rdDataA1, 32'h0);
      checkOutput({tag, " dut1 rdDataB"}, rdDataB1, 32'h0);
      checkOutput({tag, " dut1 busyA"}, 32'(busyA1), 32'h0);
      checkOutput({tag, " dut1 busyB"}, 32'(busyB1), 32'h0);
      checkOutput({tag, " dut1 addrErr"}, 32'(addrErr1), 32'h0);
   endtask

   // Monitor: shortly after each rising edge, compare the DUT outputs
   // against the oldest queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb0.size() > 0) begin
            e = sb0.pop_front();
            checkOutput("dut0 rdDataA", rdDataA0, e.da);
            checkOutput("dut0 busyA", 32'(busyA0), 32'(e.ba));
            checkOutput("dut0 rdDataB", rdDataB0, e.db);
            checkOutput("dut0 busyB", 32'(busyB0), 32'(e.bb));
            checkOutput("dut0 addrErr", 32'(addrErr0), 32'(e.er));
         end
         if (sb1.size() > 0) begin
            e = sb1.pop_front();
            checkOutput("dut1 rdDataA", rdDataA1, e.da);
            checkOutput("dut1 busyA", 32'(busyA1), 32'(e.ba));
            checkOutput("dut1 rdDataB", rdDataB1, e.db);
            checkOutput("dut1 busyB", 32'(busyB1), 32'(e.bb));
            checkOutput("dut1 addrErr", 32'(addrErr1), 32'(e.er));
         end
      end
   end

   task automatic drainQueues();
      for (int i = 0; i < 20 && (sb0.size() > 0 || sb1.size() > 0); i++)
         @(posedge clk);
      #3;
      checks++;
      if (sb0.size() > 0 || sb1.size() > 0) begin
         failures++;
         $display("[TB] FAIL drain pending=%0d required=0", sb0.size() + sb1.size());
      end
   endtask

   initial begin
      rst_n = 1'b0;
      wrEn = 0; wrAddr = 0; wrData = 0;
      rdEnA = 0; rdAddrA = 0; rdEnB = 0; rdAddrB = 0;
      rsvEn = 0; rsvAddr = 0; errClr = 0;
      modelReset();
      repeat (2) @(posedge clk);
      #1;
      checkAllZero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // After reset, every in-window address reads as zero and not busy.
      for (int i = 0; i < NREG; i++)
         applyStimulus(0, 0, 0, 1, 5'(BASE + i), 1, 5'(BASE + NREG - 1 - i), 0, 0, 0);

      // Write a register, then read it back on the next cycle.
      applyStimulus(1, 10, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 1, 10, 0, 0, 0, 0, 0);

      // Same-cycle bypass on both ports, then a normal read of the same register.
      applyStimulus(1, 12, 32'h00001234, 1, 12, 1, 12, 0, 0, 0);
      applyStimulus(0, 0, 0, 1, 12, 1, 12, 0, 0, 0);

      // Scoreboard: reserve, write plus reserve (set wins), then write only.
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
      applyStimulus(0, 0, 0, 1, 9, 0, 0, 0, 0, 0);
      applyStimulus(1, 9, 32'hA5A5A5A5, 1, 9, 0, 0, 1, 9, 0);
      applyStimulus(1, 9, 32'h5A5A5A5A, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 1, 9, 0, 0, 0, 0, 0);

      // Out-of-window accesses and the sticky error flag.
      applyStimulus(1, 3, 32'hBAD0BAD0, 0, 0, 1, 24, 0, 0, 0);
      applyStimulus(0, 0, 0, 1, 7, 0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 1, 11, 1, 23, 0, 0, 0);

      // Index 0 (address 8): hardwired to zero in dut1, an ordinary register in dut0.
      applyStimulus(1, 8, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 8, 0);
      applyStimulus(0, 0, 0, 1, 8, 1, 8, 0, 0, 0);
      applyStimulus(1, 8, 32'h01234567, 1, 8, 1, 8, 1, 8, 0);

      // Random traffic, including read-enable-low cycles that must hold the outputs.
      for (int n = 0; n < 600; n++)
         applyStimulus(1'($urandom_range(0, 1)), randAddr(), $urandom(),
                       1'($urandom_range(0, 3) != 0), randAddr(),
                       1'($urandom_range(0, 3) != 0), randAddr(),
                       1'($urandom_range(0, 2) == 0), randAddr(),
                       1'($urandom_range(0, 9) == 0));
      idle();
      drainQueues();

      // Reset asserted in the middle of a write: outputs clear at once, and
      // the write and reserve of that cycle are lost.
      @(negedge clk);
      wrEn = 1; wrAddr = 15; wrData = 32'hCAFEF00D;
      rsvEn = 1; rsvAddr = 15; rdEnA = 1; rdAddrA = 15;
      rdEnB = 1; rdAddrB = 2; errClr = 0;
      #2;
      rst_n = 1'b0;
      #1;
      checkAllZero("async reset");
      @(posedge clk);
      @(negedge clk);
      wrEn = 0; rsvEn = 0; rdEnA = 0; rdEnB = 0;
      rst_n = 1'b1;
      modelReset();
      applyStimulus(0, 0, 0, 1, 15, 1, 15, 0, 0, 0);
      for (int n = 0; n < 40; n++)
         applyStimulus(1'($urandom_range(0, 1)), randAddr(), $urandom(),
                       1, randAddr(), 1, randAddr(),
                       1'($urandom_range(0, 1)), randAddr(), 0);
      idle();
      drainQueues();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
